// File: rtl/game_flow_ctrl_if.sv
// Game-flow controller bus: game events in, state windows / score / level out.
// The master side (object_ctrl, keypad and the bench) drives the event inputs.
// The slave side (game_flow_ctrl) drives the display and status outputs.
interface game_flow_ctrl_if #(
    parameter int SCORE_DIGITS = 2,
    parameter int BALL_W       = 2
);
    // Event inputs to the controller
    logic                      start_en;
    logic                      pause_req;
    logic                      frame_tick;
    logic                      update_tick;
    logic                      hit;
    logic                      miss;

    // Status and display outputs from the controller
    logic                      game_start;
    logic                      serve_active;
    logic                      win_init;
    logic                      win_play;
    logic                      win_pause;
    logic                      win_over;
    logic [4*SCORE_DIGITS-1:0] score_bcd;
    logic [4*SCORE_DIGITS-1:0] high_bcd;
    logic [BALL_W-1:0]         balls_left;
    logic [2:0]                level;
    logic                      level_up;

    modport master (
        output start_en, pause_req, frame_tick, update_tick, hit, miss,
        input  game_start, serve_active, win_init, win_play, win_pause, win_over,
        input  score_bcd, high_bcd, balls_left, level, level_up
    );

    modport slave (
        input  start_en, pause_req, frame_tick, update_tick, hit, miss,
        output game_start, serve_active, win_init, win_play, win_pause, win_over,
        output score_bcd, high_bcd, balls_left, level, level_up
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game-level controller for the VGA ping-pong design.
// It sequences IDLE/SERVE/PLAY/PAUSE/OVER and holds the BCD score, the high
// score, the number of balls left and the difficulty level.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_IDLE  | title screen; start_en begins a new game
//  S_SERVE | ball held at the serve position for SERVE_FRAMES frame_ticks
//  S_PLAY  | rally running; hit/miss are qualified by update_tick
//  S_PAUSE | everything frozen until the next pause_req
//  S_OVER  | game-over screen for OVER_FRAMES frame_ticks, then S_IDLE
module game_flow_ctrl #(
    parameter int SCORE_DIGITS = 2,
    parameter int BALL_W       = 2,
    parameter int INIT_BALLS   = 3,
    parameter int SERVE_FRAMES = 32,
    parameter int OVER_FRAMES  = 128,
    parameter int LEVEL_STEP   = 10,
    parameter int MAX_LEVEL    = 7
) (
    input  logic             clk,
    input  logic             rst,
    game_flow_ctrl_if.slave  gf
);

    localparam int SW   = 4 * SCORE_DIGITS;
    localparam int ST_W = $clog2(SERVE_FRAMES + 1);
    localparam int OT_W = $clog2(OVER_FRAMES + 1);
    localparam int HC_W = $clog2(LEVEL_STEP + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE,
        S_PLAY,
        S_PAUSE,
        S_OVER
    } state_t;

    state_t            state_q;
    logic [ST_W-1:0]   serve_tmr_q;
    logic [OT_W-1:0]   over_tmr_q;
    logic [HC_W-1:0]   hits_q;
    logic [SW-1:0]     score_q;
    logic [SW-1:0]     high_q;
    logic [BALL_W-1:0] balls_q;
    logic [2:0]        level_q;

    logic              game_start_q;
    logic              level_up_q;
    logic              serve_active_q;
    logic              win_init_q;
    logic              win_play_q;
    logic              win_pause_q;
    logic              win_over_q;

    logic              hit_ev;
    logic              miss_ev;
    logic              level_wrap_d;
    logic [SW-1:0]     score_inc_d;
    logic [SW-1:0]     score_fin_d;

    // Score +1 with BCD ripple carry.
    // An all-9s score has no representable successor, so it holds at all-9s.
    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        if (carry) begin
            r = v;
        end
        return r;
    endfunction

    assign hit_ev       = gf.update_tick & gf.hit;
    assign miss_ev      = gf.update_tick & gf.miss;
    assign level_wrap_d = (hits_q == HC_W'(LEVEL_STEP - 1));

    // Next score on a hit, and the score that stands at the end of this tick.
    // The high-score compare uses score_fin_d so that a hit on the final miss
    // tick still counts.
    always_comb begin
        score_inc_d = bcd_inc(score_q);
        score_fin_d = hit_ev ? score_inc_d : score_q;
    end

    // Game sequencer.
    // It also holds the score/level/ball counters and the registered windows.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            serve_tmr_q    <= '0;
            over_tmr_q     <= '0;
            hits_q         <= '0;
            score_q        <= '0;
            high_q         <= '0;
            balls_q        <= BALL_W'(INIT_BALLS);
            level_q        <= 3'd0;
            game_start_q   <= 1'b0;
            level_up_q     <= 1'b0;
            serve_active_q <= 1'b0;
            win_init_q     <= 1'b0;
            win_play_q     <= 1'b0;
            win_pause_q    <= 1'b0;
            win_over_q     <= 1'b0;
        end else begin
            game_start_q   <= 1'b0;
            level_up_q     <= 1'b0;
            // Windows follow the state one cycle late.
            // This keeps them glitch-free for the pixel mux.
            win_init_q     <= (state_q == S_IDLE);
            win_play_q     <= (state_q == S_PLAY);
            win_pause_q    <= (state_q == S_PAUSE);
            win_over_q     <= (state_q == S_OVER);
            serve_active_q <= (state_q == S_SERVE);

            case (state_q)
                S_IDLE: begin
                    if (gf.start_en) begin
                        state_q      <= S_SERVE;
                        game_start_q <= 1'b1;
                        score_q      <= '0;
                        balls_q      <= BALL_W'(INIT_BALLS);
                        level_q      <= 3'd0;
                        hits_q       <= '0;
                        serve_tmr_q  <= ST_W'(SERVE_FRAMES);
                    end
                end

                S_SERVE: begin
                    if (gf.frame_tick) begin
                        if (serve_tmr_q == ST_W'(1)) begin
                            state_q     <= S_PLAY;
                            serve_tmr_q <= '0;
                        end else begin
                            serve_tmr_q <= serve_tmr_q - ST_W'(1);
                        end
                    end
                end

                S_PLAY: begin
                    if (hit_ev) begin
                        score_q <= score_inc_d;
                        if (level_wrap_d) begin
                            hits_q <= '0;
                            if (level_q < 3'(MAX_LEVEL)) begin
                                level_q    <= level_q + 3'd1;
                                level_up_q <= 1'b1;
                            end
                        end else begin
                            hits_q <= hits_q + HC_W'(1);
                        end
                    end

                    if (miss_ev) begin
                        if (balls_q != '0) begin
                            balls_q <= balls_q - BALL_W'(1);
                        end
                        if (balls_q <= BALL_W'(1)) begin
                            state_q    <= S_OVER;
                            over_tmr_q <= OT_W'(OVER_FRAMES);
                            // BCD digits preserve ordering, so a plain unsigned compare works.
                            if (score_fin_d > high_q) begin
                                high_q <= score_fin_d;
                            end
                        end else begin
                            state_q     <= S_SERVE;
                            serve_tmr_q <= ST_W'(SERVE_FRAMES);
                        end
                    end else if (gf.pause_req) begin
                        state_q <= S_PAUSE;
                    end
                end

                S_PAUSE: begin
                    if (gf.pause_req) begin
                        state_q <= S_PLAY;
                    end
                end

                S_OVER: begin
                    if (gf.frame_tick) begin
                        if (over_tmr_q == OT_W'(1)) begin
                            state_q    <= S_IDLE;
                            over_tmr_q <= '0;
                        end else begin
                            over_tmr_q <= over_tmr_q - OT_W'(1);
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gf.game_start   = game_start_q;
    assign gf.serve_active = serve_active_q;
    assign gf.win_init     = win_init_q;
    assign gf.win_play     = win_play_q;
    assign gf.win_pause    = win_pause_q;
    assign gf.win_over     = win_over_q;
    assign gf.score_bcd    = score_q;
    assign gf.high_bcd     = high_q;
    assign gf.balls_left   = balls_q;
    assign gf.level        = level_q;
    assign gf.level_up     = level_up_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl.
// A table of {inputs, repeat count, expected outputs} records walks through
// three full games. Hand-written sequences then check the start-pulse timing
// and a reset in the middle of a game.
module tb_game_flow_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int tests  = 0;
    int failed = 0;
    int gs_cnt = 0;
    int lu_cnt = 0;

    game_flow_ctrl_if #(.SCORE_DIGITS(2), .BALL_W(2)) gf ();

    game_flow_ctrl dut (
        .clk (clk),
        .rst (rst),
        .gf  (gf)
    );

    always #5 clk = ~clk;

    // Count the cycles in which each pulse output is high.
    // A pulse that lasts two cycles is counted twice.
    always @(posedge clk) begin
        if (gf.game_start) gs_cnt <= gs_cnt + 1;
        if (gf.level_up)   lu_cnt <= lu_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic        st, pr, ft, ut, h, m;
        int          reps;
        logic [3:0]  win;      // {init, play, pause, over}
        logic        srv;
        logic [7:0]  score;
        logic [7:0]  high;
        logic [1:0]  balls;
        logic [2:0]  lvl;
        int          gs;
        int          lu;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic st, input logic pr, input logic ft,
                       input logic ut, input logic h, input logic m, input int reps,
                       input logic [3:0] win, input logic srv, input logic [7:0] score,
                       input logic [7:0] high, input logic [1:0] balls, input logic [2:0] lvl,
                       input int gs, input int lu);
        vec_t v;
        v.name = n; v.st = st; v.pr = pr; v.ft = ft; v.ut = ut; v.h = h; v.m = m;
        v.reps = reps; v.win = win; v.srv = srv; v.score = score; v.high = high;
        v.balls = balls; v.lvl = lvl; v.gs = gs; v.lu = lu;
        vecs.push_back(v);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic pr, input logic ft,
                         input logic ut, input logic h, input logic m);
        gf.start_en    = st;
        gf.pause_req   = pr;
        gf.frame_tick  = ft;
        gf.update_tick = ut;
        gf.hit         = h;
        gf.miss        = m;
    endtask

    task automatic check(input string n, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic check_all(input string n, input logic [3:0] win, input logic srv,
                             input logic [7:0] score, input logic [7:0] high,
                             input logic [1:0] balls, input logic [2:0] lvl);
        check({n, ".win"},   int'({gf.win_init, gf.win_play, gf.win_pause, gf.win_over}), int'(win));
        check({n, ".serve"}, int'(gf.serve_active), int'(srv));
        check({n, ".score"}, int'(gf.score_bcd), int'(score));
        check({n, ".high"},  int'(gf.high_bcd), int'(high));
        check({n, ".balls"}, int'(gf.balls_left), int'(balls));
        check({n, ".level"}, int'(gf.level), int'(lvl));
    endtask

    // One pulse cycle with the given inputs, then one cycle with all inputs idle.
    task automatic pulse(input logic st, input logic pr, input logic ft,
                         input logic ut, input logic h, input logic m);
        drive(st, pr, ft, ut, h, m);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        cyc();
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);

        //   name          st pr ft ut h  m  reps  win      srv score  high   b  lvl gs lu
        add("idle",        0, 0, 0, 0, 0, 0, 1,   4'b1000, 0, 8'h00, 8'h00, 3, 0, 0, 0);
        add("start",       1, 0, 0, 0, 0, 0, 1,   4'b0000, 1, 8'h00, 8'h00, 3, 0, 1, 0);
        add("serve31",     0, 0, 1, 0, 0, 0, 31,  4'b0000, 1, 8'h00, 8'h00, 3, 0, 1, 0);
        add("serve32",     0, 0, 1, 0, 0, 0, 1,   4'b0100, 0, 8'h00, 8'h00, 3, 0, 1, 0);
        add("hit9",        0, 0, 0, 1, 1, 0, 9,   4'b0100, 0, 8'h09, 8'h00, 3, 0, 1, 0);
        add("hit10",       0, 0, 0, 1, 1, 0, 1,   4'b0100, 0, 8'h10, 8'h00, 3, 1, 1, 1);
        add("hit12",       0, 0, 0, 1, 1, 0, 2,   4'b0100, 0, 8'h12, 8'h00, 3, 1, 1, 1);
        add("no_update",   0, 0, 1, 0, 1, 1, 2,   4'b0100, 0, 8'h12, 8'h00, 3, 1, 1, 1);
        add("pause",       0, 1, 0, 0, 0, 0, 1,   4'b0010, 0, 8'h12, 8'h00, 3, 1, 1, 1);
        add("paused",      1, 0, 1, 1, 1, 1, 3,   4'b0010, 0, 8'h12, 8'h00, 3, 1, 1, 1);
        add("resume",      0, 1, 0, 0, 0, 0, 1,   4'b0100, 0, 8'h12, 8'h00, 3, 1, 1, 1);
        add("miss1",       0, 0, 0, 1, 0, 1, 1,   4'b0000, 1, 8'h12, 8'h00, 2, 1, 1, 1);
        add("serve_ign",   0, 1, 0, 1, 1, 1, 2,   4'b0000, 1, 8'h12, 8'h00, 2, 1, 1, 1);
        add("serve_b",     0, 0, 1, 0, 0, 0, 32,  4'b0100, 0, 8'h12, 8'h00, 2, 1, 1, 1);
        add("hit75",       0, 0, 0, 1, 1, 0, 63,  4'b0100, 0, 8'h75, 8'h00, 2, 7, 1, 7);
        add("miss2",       0, 0, 0, 1, 0, 1, 1,   4'b0000, 1, 8'h75, 8'h00, 1, 7, 1, 7);
        add("serve_c",     0, 0, 1, 0, 0, 0, 32,  4'b0100, 0, 8'h75, 8'h00, 1, 7, 1, 7);
        add("hit_miss",    0, 0, 0, 1, 1, 1, 1,   4'b0001, 0, 8'h76, 8'h76, 0, 7, 1, 7);
        add("over127",     1, 0, 1, 0, 0, 0, 127, 4'b0001, 0, 8'h76, 8'h76, 0, 7, 1, 7);
        add("over128",     0, 0, 1, 0, 0, 0, 1,   4'b1000, 0, 8'h76, 8'h76, 0, 7, 1, 7);
        add("start2",      1, 0, 0, 0, 0, 0, 1,   4'b0000, 1, 8'h00, 8'h76, 3, 0, 2, 7);
        add("serve2",      0, 0, 1, 0, 0, 0, 32,  4'b0100, 0, 8'h00, 8'h76, 3, 0, 2, 7);
        add("hit99",       0, 0, 0, 1, 1, 0, 99,  4'b0100, 0, 8'h99, 8'h76, 3, 7, 2, 14);
        add("hit_sat",     0, 0, 0, 1, 1, 0, 1,   4'b0100, 0, 8'h99, 8'h76, 3, 7, 2, 14);
        add("miss2a",      0, 0, 0, 1, 0, 1, 1,   4'b0000, 1, 8'h99, 8'h76, 2, 7, 2, 14);
        add("serve2b",     0, 0, 1, 0, 0, 0, 32,  4'b0100, 0, 8'h99, 8'h76, 2, 7, 2, 14);
        add("miss2b",      0, 0, 0, 1, 0, 1, 1,   4'b0000, 1, 8'h99, 8'h76, 1, 7, 2, 14);
        add("serve2c",     0, 0, 1, 0, 0, 0, 32,  4'b0100, 0, 8'h99, 8'h76, 1, 7, 2, 14);
        add("miss_pause",  0, 1, 0, 1, 0, 1, 1,   4'b0001, 0, 8'h99, 8'h99, 0, 7, 2, 14);
        add("over2",       0, 0, 1, 0, 0, 0, 128, 4'b1000, 0, 8'h99, 8'h99, 0, 7, 2, 14);
        add("start3",      1, 0, 0, 0, 0, 0, 1,   4'b0000, 1, 8'h00, 8'h99, 3, 0, 3, 14);
        add("serve3",      0, 0, 1, 0, 0, 0, 32,  4'b0100, 0, 8'h00, 8'h99, 3, 0, 3, 14);
        add("hit5",        0, 0, 0, 1, 1, 0, 5,   4'b0100, 0, 8'h05, 8'h99, 3, 0, 3, 14);
        add("miss3a",      0, 0, 0, 1, 0, 1, 1,   4'b0000, 1, 8'h05, 8'h99, 2, 0, 3, 14);
        add("serve3b",     0, 0, 1, 0, 0, 0, 32,  4'b0100, 0, 8'h05, 8'h99, 2, 0, 3, 14);
        add("miss3b",      0, 0, 0, 1, 0, 1, 1,   4'b0000, 1, 8'h05, 8'h99, 1, 0, 3, 14);
        add("serve3c",     0, 0, 1, 0, 0, 0, 32,  4'b0100, 0, 8'h05, 8'h99, 1, 0, 3, 14);
        add("miss3c",      0, 0, 0, 1, 0, 1, 1,   4'b0001, 0, 8'h05, 8'h99, 0, 0, 3, 14);
        add("over3",       0, 0, 1, 0, 0, 0, 128, 4'b1000, 0, 8'h05, 8'h99, 0, 0, 3, 14);

        // Reset state
        rst = 1'b1;
        repeat (3) cyc();
        check_all("reset", 4'b0000, 0, 8'h00, 8'h00, 3, 0);
        check("reset.game_start", int'(gf.game_start), 0);
        check("reset.level_up", int'(gf.level_up), 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                pulse(vecs[i].st, vecs[i].pr, vecs[i].ft, vecs[i].ut, vecs[i].h, vecs[i].m);
            end
            check_all(vecs[i].name, vecs[i].win, vecs[i].srv, vecs[i].score,
                      vecs[i].high, vecs[i].balls, vecs[i].lvl);
            check({vecs[i].name, ".gs_cnt"}, gs_cnt, vecs[i].gs);
            check({vecs[i].name, ".lu_cnt"}, lu_cnt, vecs[i].lu);
        end

        // Start-pulse timing: game_start appears right after the start edge.
        // The windows and serve_active follow one cycle later.
        drive(1, 0, 0, 0, 0, 0);
        cyc();
        check("lag.game_start_a", int'(gf.game_start), 1);
        check("lag.win_init_a", int'(gf.win_init), 1);
        check("lag.serve_a", int'(gf.serve_active), 0);
        drive(0, 0, 0, 0, 0, 0);
        cyc();
        check("lag.game_start_b", int'(gf.game_start), 0);
        check("lag.win_init_b", int'(gf.win_init), 0);
        check("lag.serve_b", int'(gf.serve_active), 1);
        check("lag.gs_cnt", gs_cnt, 4);

        // Reset in the middle of play
        for (int k = 0; k < 32; k++) pulse(0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++)  pulse(0, 0, 0, 1, 1, 0);
        check_all("pre_rst", 4'b0100, 0, 8'h03, 8'h99, 3, 0);
        pulse(0, 0, 0, 1, 0, 1);
        check("pre_rst.balls2", int'(gf.balls_left), 2);
        for (int k = 0; k < 32; k++) pulse(0, 0, 1, 0, 0, 0);
        rst = 1'b1;
        cyc();
        check_all("mid_rst", 4'b0000, 0, 8'h00, 8'h00, 3, 0);
        rst = 1'b0;
        cyc();
        check_all("post_rst", 4'b1000, 0, 8'h00, 8'h00, 3, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
